seg_scan_drv: RTL and testbench

SEG_SCAN_DRV -- requirements
Module: seg_scan_drv

---
 rtl/seg_scan_drv_pkg.sv | 97 +++++++++
 rtl/seg_scan_drv_tick_gen.sv | 31 +++
 rtl/seg_scan_drv.sv | 126 ++++++++++++
 tb/tb_seg_scan_drv.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_drv_pkg.sv
// Shared glyph codes, segment patterns and the glyph-to-segment decoder for the
// multiplexed 8-digit seven-segment display. Also imported by the game controller.
package seg_scan_drv_pkg;

   localparam int unsigned NUM_DIGITS = 8;

   typedef logic [5:0] glyph_t;
   // Segment order {dp,g,f,e,d,c,b,a}, active-low.
   typedef logic [7:0] seg_t;

   typedef enum logic {
      PhaseOn  = 1'b0,
      PhaseOff = 1'b1
   } blink_phase_e;

   // Glyph codes driven by the game controller.
   localparam glyph_t GLYPH_DASH    = 6'b111111;
   localparam glyph_t GLYPH_ONE_ALT = 6'b000011;
   localparam glyph_t GLYPH_TWO_ALT = 6'b000101;
   localparam glyph_t GLYPH_P       = 6'b010101;
   localparam glyph_t GLYPH_S       = 6'b011011;
   localparam glyph_t GLYPH_U       = 6'b011111;
   localparam glyph_t GLYPH_U_ALT   = 6'b011110;
   localparam glyph_t GLYPH_E       = 6'b011101;
   localparam glyph_t GLYPH_G       = 6'b001101;
   localparam glyph_t GLYPH_C_LO    = 6'b011001;
   localparam glyph_t GLYPH_B_LO    = 6'b010111;

   // Decimal digit v is carried as {0, v, 0}.
   function automatic glyph_t glyph_digit(input logic [3:0] v);
      return {1'b0, v, 1'b0};
   endfunction

   // Segment patterns, active-low, dp always off.
   localparam seg_t SEG_OFF  = 8'hFF;
   localparam seg_t SEG_DASH = 8'hBF;
   localparam seg_t SEG_0    = 8'hC0;
   localparam seg_t SEG_1    = 8'hF9;
   localparam seg_t SEG_2    = 8'hA4;
   localparam seg_t SEG_3    = 8'hB0;
   localparam seg_t SEG_4    = 8'h99;
   localparam seg_t SEG_5    = 8'h92;
   localparam seg_t SEG_6    = 8'h82;
   localparam seg_t SEG_7    = 8'hF8;
   localparam seg_t SEG_8    = 8'h80;
   localparam seg_t SEG_9    = 8'h90;
   localparam seg_t SEG_P    = 8'h8C;
   localparam seg_t SEG_S    = 8'h92;
   localparam seg_t SEG_U    = 8'hC1;
   localparam seg_t SEG_E    = 8'h86;
   localparam seg_t SEG_G    = 8'hC2;
   localparam seg_t SEG_C_LO = 8'hA7;
   localparam seg_t SEG_B_LO = 8'h83;

   function automatic seg_t digit_seg(input logic [3:0] v);
      seg_t r;
      case (v)
         4'd0:    r = SEG_0;
         4'd1:    r = SEG_1;
         4'd2:    r = SEG_2;
         4'd3:    r = SEG_3;
         4'd4:    r = SEG_4;
         4'd5:    r = SEG_5;
         4'd6:    r = SEG_6;
         4'd7:    r = SEG_7;
         4'd8:    r = SEG_8;
         4'd9:    r = SEG_9;
         default: r = SEG_OFF;
      endcase
      return r;
   endfunction

   // Unknown codes blank the digit rather than showing garbage.
   function automatic seg_t glyph_decode(input glyph_t code);
      seg_t r;
      if (!code[5] && !code[0] && (code[4:1] <= 4'd9)) begin
         r = digit_seg(code[4:1]);
      end else begin
         case (code)
            GLYPH_ONE_ALT:          r = SEG_1;
            GLYPH_TWO_ALT:          r = SEG_2;
            GLYPH_P:                r = SEG_P;
            GLYPH_S:                r = SEG_S;
            GLYPH_U, GLYPH_U_ALT:   r = SEG_U;
            GLYPH_E:                r = SEG_E;
            GLYPH_G:                r = SEG_G;
            GLYPH_C_LO:             r = SEG_C_LO;
            GLYPH_B_LO:             r = SEG_B_LO;
            GLYPH_DASH:             r = SEG_DASH;
            default:                r = SEG_OFF;
         endcase
      end
      // Decimal point is never lit.
      return r | 8'h80;
   endfunction

endpackage

// File: rtl/seg_scan_drv_tick_gen.sv
// Modulo-MODULUS counter with a single-cycle terminal-count pulse.
// i_clr has priority and returns the count to zero.
module seg_scan_drv_tick_gen #(
   parameter int unsigned MODULUS = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic i_en,
   input  logic i_clr,
   output logic o_tick
);

   localparam int unsigned CW = (MODULUS > 1) ? $clog2(MODULUS) : 1;
   localparam logic [CW-1:0] LAST = CW'(MODULUS - 1);

   logic [CW-1:0] r_count;

   assign o_tick = i_en & ~i_clr & (r_count == LAST);

   // Count while enabled, wrap at terminal count, clear on request.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_en) begin
         r_count <= o_tick ? '0 : r_count + CW'(1);
      end
   end

endmodule

// File: rtl/seg_scan_drv.sv
// Time-multiplexed scan driver for an 8-digit common-anode seven-segment display,
// with frame-buffered glyphs (no mid-frame tearing) and whole-display blinking.
module seg_scan_drv
   import seg_scan_drv_pkg::*;
#(
   parameter int unsigned DIGIT_TICKS = 100000,
   parameter int unsigned BLINK_TICKS = 25000000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [5:0] d1,
   input  logic [5:0] d2,
   input  logic [5:0] d3,
   input  logic [5:0] d4,
   input  logic [5:0] d5,
   input  logic [5:0] d6,
   input  logic [5:0] d7,
   input  logic [5:0] d8,
   input  logic       blink_en,
   output logic [7:0] an,
   output logic [7:0] seg
);

   logic         w_scan_tick;
   logic         w_blink_tick;
   logic         w_snapshot;
   glyph_t       w_digits  [NUM_DIGITS];
   glyph_t       w_frame_d [NUM_DIGITS];
   logic [2:0]   w_idx_d;
   logic         w_live_d;
   blink_phase_e w_phase_d;
   logic [7:0]   w_an_d;
   seg_t         w_seg_d;

   glyph_t       r_frame [NUM_DIGITS];
   logic [2:0]   r_idx;
   logic         r_live;
   blink_phase_e r_phase;
   logic [7:0]   r_an;
   seg_t         r_seg;

   assign w_digits[0] = d1;
   assign w_digits[1] = d2;
   assign w_digits[2] = d3;
   assign w_digits[3] = d4;
   assign w_digits[4] = d5;
   assign w_digits[5] = d6;
   assign w_digits[6] = d7;
   assign w_digits[7] = d8;

   seg_scan_drv_tick_gen #(
      .MODULUS (DIGIT_TICKS)
   ) u_scan_tick (
      .clock  (clock),
      .reset  (reset),
      .i_en   (1'b1),
      .i_clr  (1'b0),
      .o_tick (w_scan_tick)
   );

   // Blink timing restarts from zero every time blinking is (re)enabled.
   seg_scan_drv_tick_gen #(
      .MODULUS (BLINK_TICKS)
   ) u_blink_tick (
      .clock  (clock),
      .reset  (reset),
      .i_en   (blink_en),
      .i_clr  (~blink_en),
      .o_tick (w_blink_tick)
   );

   // r_live stays low until the first scan tick after reset, so that tick only moves
   // idx 7->0 and the first snapshot lands at the end of the first full frame.
   assign w_snapshot = w_scan_tick & r_live & (r_idx == 3'd7);

   // Next-state for scan position, frame buffer, blink phase and the output registers.
   always_comb begin
      w_idx_d   = r_idx;
      w_live_d  = r_live | w_scan_tick;
      w_frame_d = r_frame;
      w_phase_d = r_phase;
      if (w_scan_tick) begin
         w_idx_d = r_idx + 3'd1;
      end
      if (w_snapshot) begin
         w_frame_d = w_digits;
      end
      if (!blink_en) begin
         w_phase_d = PhaseOn;
      end else if (w_blink_tick) begin
         w_phase_d = (r_phase == PhaseOn) ? PhaseOff : PhaseOn;
      end
      // Outputs are computed from next state so they line up with the new idx.
      if (!w_live_d || (w_phase_d == PhaseOff)) begin
         w_an_d = 8'hFF;
      end else begin
         w_an_d = ~(8'h01 << w_idx_d);
      end
      w_seg_d = w_live_d ? glyph_decode(w_frame_d[w_idx_d]) : SEG_OFF;
   end

   // All scan/blink state and the registered an/seg outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_idx   <= 3'd7;
         r_live  <= 1'b0;
         r_phase <= PhaseOn;
         r_an    <= 8'hFF;
         r_seg   <= SEG_OFF;
         for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            r_frame[i] <= GLYPH_DASH;
         end
      end else begin
         r_idx   <= w_idx_d;
         r_live  <= w_live_d;
         r_phase <= w_phase_d;
         r_an    <= w_an_d;
         r_seg   <= w_seg_d;
         r_frame <= w_frame_d;
      end
   end

   assign an  = r_an;
   assign seg = r_seg;

endmodule

// File: tb/tb_seg_scan_drv.sv
// Scoreboard bench for seg_scan_drv: a cycle-level reference model pushes the expected
// an/seg for every cycle; a monitor pops and compares on the falling edge.
module tb_seg_scan_drv;

   localparam int unsigned DT = 4;
   localparam int unsigned BT = 64;

   typedef struct packed {
      int unsigned cyc;
      logic [7:0]  an;
      logic [7:0]  seg;
   } exp_t;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] d [8];
   logic       blink_en = 1'b0;
   logic [7:0] an;
   logic [7:0] seg;

   exp_t        exp_q [$];
   int          n_checks = 0;
   int          n_fail = 0;
   bit          mon_en = 1'b0;

   // Reference model state: c is the number (from 1) of the cycle being driven.
   int unsigned c;
   int unsigned brun;
   logic [5:0]  frame [8];
   logic [5:0]  pool [12];

   seg_scan_drv #(
      .DIGIT_TICKS (DT),
      .BLINK_TICKS (BT)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .d1       (d[0]),
      .d2       (d[1]),
      .d3       (d[2]),
      .d4       (d[3]),
      .d5       (d[4]),
      .d6       (d[5]),
      .d7       (d[6]),
      .d8       (d[7]),
      .blink_en (blink_en),
      .an       (an),
      .seg      (seg)
   );

   always #5 clock = ~clock;

   function automatic logic [7:0] ref_seg(input logic [5:0] code);
      logic [3:0] v;
      v = code[4:1];
      if (!code[5] && !code[0] && v <= 4'd9) begin
         case (v)
            4'd0: return 8'hC0;
            4'd1: return 8'hF9;
            4'd2: return 8'hA4;
            4'd3: return 8'hB0;
            4'd4: return 8'h99;
            4'd5: return 8'h92;
            4'd6: return 8'h82;
            4'd7: return 8'hF8;
            4'd8: return 8'h80;
            default: return 8'h90;
         endcase
      end
      case (code)
         6'b000011: return 8'hF9;
         6'b000101: return 8'hA4;
         6'b010101: return 8'h8C;
         6'b011011: return 8'h92;
         6'b011111: return 8'hC1;
         6'b011110: return 8'hC1;
         6'b011101: return 8'h86;
         6'b001101: return 8'hC2;
         6'b011001: return 8'hA7;
         6'b010111: return 8'h83;
         6'b111111: return 8'hBF;
         default:   return 8'hFF;
      endcase
   endfunction

   function automatic logic [5:0] rand_code();
      if ($urandom_range(0, 3) == 0) return 6'($urandom);
      return pool[$urandom_range(0, 11)];
   endfunction

   // Digit currently lit during cycle c, or -1 before the first tick.
   function automatic int vis_idx();
      int unsigned td;
      td = (c - 1) / DT;
      if (td == 0) return -1;
      return int'((td - 1) % 8);
   endfunction

   task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %02h expected %02h", name, act, req);
      end
   endtask

   task automatic model_reset();
      c    = 1;
      brun = 0;
      for (int i = 0; i < 8; i++) frame[i] = 6'b111111;
   endtask

   // Advance one cycle: predict the outputs of cycle c+1 from inputs held during cycle c.
   task automatic step();
      exp_t        e;
      int unsigned td;
      int unsigned k;
      int unsigned ix;
      bit          off;
      logic [7:0]  one_hot;
      if (c % DT == 0) begin
         k = c / DT;
         if (k >= 9 && k % 8 == 1) begin
            for (int i = 0; i < 8; i++) frame[i] = d[i];
         end
      end
      brun = blink_en ? brun + 1 : 0;
      off  = blink_en && (((brun / BT) % 2) == 1);
      td   = c / DT;
      e.cyc = c + 1;
      if (td == 0) begin
         e.an  = 8'hFF;
         e.seg = 8'hFF;
      end else begin
         ix      = (td - 1) % 8;
         one_hot = 8'h01;
         e.an    = off ? 8'hFF : ~(one_hot << ix);
         e.seg   = ref_seg(frame[ix]);
      end
      @(posedge clock);
      exp_q.push_back(e);
      #1;
      c++;
   endtask

   // Monitor: every cycle presents an output; compare against the oldest prediction.
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (mon_en && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check8($sformatf("cycle %0d an", e.cyc), an, e.an);
            check8($sformatf("cycle %0d seg", e.cyc), seg, e.seg);
         end
      end
   end

   initial begin
      pool = '{6'b000011, 6'b000101, 6'b010101, 6'b011011, 6'b011111, 6'b011110,
               6'b011101, 6'b001101, 6'b011001, 6'b010111, 6'b111111, 6'b001000};
      for (int i = 0; i < 8; i++) d[i] = 6'b111111;
      model_reset();
      repeat (3) @(posedge clock);
      #1;
      check8("reset an", an, 8'hFF);
      check8("reset seg", seg, 8'hFF);
      reset  = 1'b0;
      mon_en = 1'b1;

      // Power-up frames: dashes everywhere.
      repeat (40) step();

      // Digit 2 on the rightmost position.
      d[0] = 6'b000100;
      repeat (80) step();

      // Change leftmost glyph mid-frame.
      while (vis_idx() != 3) step();
      d[7] = 6'b010101;
      repeat (80) step();

      // Unlisted code blanks its digit.
      d[2] = 6'b101010;
      repeat (40) step();

      // Blinking: full run, then an early release.
      blink_en = 1'b1;
      repeat (200) step();
      blink_en = 1'b0;
      repeat (20) step();
      blink_en = 1'b1;
      repeat (99) step();
      blink_en = 1'b0;
      repeat (20) step();

      // Random glyph traffic and blink toggling.
      repeat (1500) begin
         if ($urandom_range(0, 9) == 0) d[$urandom_range(0, 7)] = rand_code();
         if ($urandom_range(0, 149) == 0) blink_en = ~blink_en;
         step();
      end
      blink_en = 1'b0;
      for (int i = 0; i < 8; i++) d[i] = rand_code();
      repeat (80) step();

      // Asynchronous reset in the middle of a frame.
      while (vis_idx() != 5) step();
      reset  = 1'b1;
      mon_en = 1'b0;
      exp_q.delete();
      #1;
      check8("async reset an", an, 8'hFF);
      check8("async reset seg", seg, 8'hFF);
      @(posedge clock);
      #1;
      reset = 1'b0;
      model_reset();
      mon_en = 1'b1;
      repeat (100) step();

      @(negedge clock);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
